axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width of all address ports.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; must be a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only when the timeout feature is compiled in).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have these client-side ports:
- i_addr  in  AXI_ADDR_WIDTH  transaction address.
- i_data  in  AXI_DATA_WIDTH  write data.
- i_start_read  in  1  read request, level.
- i_start_write  in  1  write request, level.
- o_data  out  AXI_DATA_WIDTH  read data, held until the next read completes.
- o_read_done  out  1  one-cycle pulse when a read completes.
- o_write_done  out  1  one-cycle pulse when a write completes.
- o_busy  out  1  high while a transaction is in flight.
- o_error  out  1  one-cycle pulse coincident with done when the response is not OKAY (or on timeout).
REQ-006 SHALL have these AXI master-side ports, which mirror the downstream AXI4-Lite slave:
- AR_VALID/AR_ADDR/AR_PROT out; AR_READY in.
- R_DATA/R_RESP/R_VALID in; R_READY out.
- AW_VALID/AW_ADDR/AW_PROT out; AW_READY in.
- W_DATA/W_STRB/W_VALID out; W_READY in.
- B_RESP/B_VALID in; B_READY out.
- Widths: addresses AXI_ADDR_WIDTH, data AXI_DATA_WIDTH, PROT 3, STRB AXI_DATA_WIDTH/8, RESP 2.

Function
REQ-007 SHALL allow at most one outstanding transaction, read or write.
REQ-008 SHALL use the FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-009 SHALL, in IDLE with i_start_read=1, latch i_addr and go to RD_ADDR; read wins when both starts are high in the same cycle.
REQ-010 SHALL, in IDLE with only i_start_write=1, latch i_addr and i_data and go to WR_REQ.
REQ-011 SHALL ignore starts when not in IDLE, with no queuing.
REQ-012 SHALL, in RD_ADDR, hold AR_VALID=1 with a stable AR_ADDR until AR_VALID&AR_READY, then go to RD_DATA.
REQ-013 SHALL, in RD_DATA, hold R_READY=1; on R_VALID, register R_DATA into o_data, pulse o_read_done next cycle, pulse o_error if R_RESP!=2'b00, and return to IDLE.
REQ-014 SHALL, in WR_REQ, assert AW_VALID and W_VALID together and drop each independently after its own handshake; the AW and W handshakes may occur in either order or in the same cycle.
REQ-015 SHALL go to WR_RESP once both the AW and W handshakes are done.
REQ-016 SHALL, in WR_RESP, hold B_READY=1; on B_VALID, pulse o_write_done next cycle, pulse o_error if B_RESP!=2'b00, and return to IDLE.
REQ-017 SHALL drive AR_PROT=AW_PROT=3'b000 and W_STRB all ones.
REQ-018 SHALL never let a VALID depend combinationally on a READY, and SHALL never deassert a VALID before its handshake completes.
REQ-019 SHALL give a minimum latency from start to done pulse of 3 cycles for a read and 3 cycles for a write, with the slave ready immediately.
REQ-020 SHALL drive o_busy=1 in every state except IDLE.
REQ-021 SHALL accept a new start in the cycle a done pulse is high, since the FSM is already in IDLE.

Reset
REQ-022 SHALL, on arst assertion at any time including mid-transaction, go immediately to IDLE and drive all VALID/READY outputs, o_busy, o_read_done, o_write_done and o_error to 0, o_data to 0, and the latched address/data to 0.
REQ-023 SHALL accept no transaction until the first clock edge after arst deasserts.

Configuration
REQ-024 SHALL, with AXI_MASTER_TIMEOUT_EN defined, count cycles spent outside IDLE; when the count reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, pulse done with o_error=1, and deassert all VALID/READY outputs.
REQ-025 SHALL, with AXI_MASTER_TIMEOUT_EN undefined, have no counter and wait indefinitely.

Structure
REQ-026 SHALL take the state enum type, the RESP codes (OKAY=2'b00, SLVERR=2'b10) and the PROT default from a shared package, axi4_lite_pkg.
REQ-027 SHALL be a single module with no sub-modules, because read and write share one FSM.

Verification
REQ-028 SHALL cover: read of 0x1000, slave AR_READY after 2 cycles, R_DATA=0xDEADBEEF -> o_data=0xDEADBEEF, o_read_done one pulse, o_error=0.
REQ-029 SHALL cover: write 0xCAFEF00D to 0x2000, W_READY before AW_READY -> a single AW and a single W handshake, o_write_done one pulse.
REQ-030 SHALL cover: i_start_read and i_start_write high in the same cycle -> read only, and the write issues after the start is reasserted.
REQ-031 SHALL cover: B_RESP=2'b10 -> o_write_done and o_error pulse together.
REQ-032 SHALL cover: arst asserted in RD_DATA -> AR_VALID=R_READY=o_busy=0 immediately, and a subsequent read completes normally.
REQ-033 SHALL cover, with AXI_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: slave never asserts AR_READY -> done and o_error pulse after 16 cycles, then IDLE.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite single-outstanding master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_lite_pkg;

  // Master FSM states; read and write share one controller.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  // Unprivileged, secure, data access.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns level start requests into single AXI4-Lite read/write transactions, one outstanding at a time.
// Latency: start to done pulse is 3 cycles minimum (read or write) with an always-ready slave; more with slave stalls.
// Backpressure: VALIDs are held until their handshake; starts are ignored (not queued) while busy.
//
// Ports:
//   clk, arst                       clock (rising edge), asynchronous active-high reset
//   i_addr, i_data                  transaction address / write data, captured on an accepted start
//   i_start_read, i_start_write     level requests, sampled only in IDLE; read wins a tie
//   o_data                          last read data, held until the next read completes
//   o_read_done, o_write_done       one-cycle completion pulses
//   o_error                         one-cycle pulse alongside done on a non-OKAY response or timeout
//   o_busy                          high whenever a transaction is in flight
//   AR_*, R_*, AW_*, W_*, B_*        AXI4-Lite master channels
//
// Build option: define AXI_MASTER_TIMEOUT_EN to add a watchdog that abandons a
// transaction after TIMEOUT_CYCLES cycles outside IDLE (done + o_error pulse).
// Without it the master waits on the slave indefinitely.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        arst,

  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_data,
  input  logic                        i_start_read,
  input  logic                        i_start_write,
  output logic [AXI_DATA_WIDTH-1:0]   o_data,
  output logic                        o_read_done,
  output logic                        o_write_done,
  output logic                        o_busy,
  output logic                        o_error,

  output logic                        AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  output logic [2:0]                  AR_PROT,
  input  logic                        AR_READY,

  input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]                  R_RESP,
  input  logic                        R_VALID,
  output logic                        R_READY,

  output logic                        AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  output logic [2:0]                  AW_PROT,
  input  logic                        AW_READY,

  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        W_VALID,
  input  logic                        W_READY,

  input  logic [1:0]                  B_RESP,
  input  logic                        B_VALID,
  output logic                        B_READY
);

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                        aw_done_q, w_done_q;
  logic                        rd_done_d, wr_done_d, err_d;
  logic                        start_rd, start_wr;
  logic                        aw_hs, w_hs;
  logic                        timeout;

  assign start_rd = (state_q == IDLE) && i_start_read;
  assign start_wr = (state_q == IDLE) && !i_start_read && i_start_write;

  // VALID/READY come purely from registered state, never from the far side's READY/VALID.
  assign AR_VALID = (state_q == RD_ADDR);
  assign R_READY  = (state_q == RD_DATA);
  assign AW_VALID = (state_q == WR_REQ) && !aw_done_q;
  assign W_VALID  = (state_q == WR_REQ) && !w_done_q;
  assign B_READY  = (state_q == WR_RESP);

  assign AR_ADDR  = addr_q;
  assign AW_ADDR  = addr_q;
  assign W_DATA   = wdata_q;
  assign AR_PROT  = PROT_DEFAULT;
  assign AW_PROT  = PROT_DEFAULT;
  assign W_STRB   = '1;

  assign o_busy   = (state_q != IDLE);

  assign aw_hs    = AW_VALID && AW_READY;
  assign w_hs     = W_VALID && W_READY;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Counts cycles spent outside IDLE; the watchdog can never let it wrap
  // because hitting CNT_LAST forces the FSM back to IDLE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires on the last of TIMEOUT_CYCLES cycles outside IDLE.
  assign timeout = (state_q != IDLE) && (cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rd) begin
          state_d = RD_ADDR;
        end else if (start_wr) begin
          state_d = WR_REQ;
        end
      end
      RD_ADDR: begin
        if (AR_READY) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (R_VALID) begin
          state_d   = IDLE;
          rd_done_d = 1'b1;
          err_d     = (R_RESP != RESP_OKAY);
        end
      end
      WR_REQ: begin
        // Each channel is complete if it handshook earlier or handshakes now.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (B_VALID) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
          err_d     = (B_RESP != RESP_OKAY);
        end
      end
      default: state_d = IDLE;
    endcase

    // A genuine completion in the watchdog's last cycle takes precedence.
    if (timeout && (state_d != IDLE)) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      rd_done_d = (state_q == RD_ADDR) || (state_q == RD_DATA);
      wr_done_d = (state_q == WR_REQ) || (state_q == WR_RESP);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      o_data       <= '0;
      o_read_done  <= 1'b0;
      o_write_done <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_read_done  <= rd_done_d;
      o_write_done <= wr_done_d;
      o_error      <= err_d;

      if (start_rd || start_wr) begin
        addr_q <= i_addr;
      end
      if (start_wr) begin
        wdata_q <= i_data;
      end
      if ((state_q == RD_DATA) && R_VALID) begin
        o_data <= R_DATA;
      end

      // Per-channel "already handshaken" flags live only for the WR_REQ phase.
      if (state_q != WR_REQ) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-programmable AXI4-Lite slave plus directed and random transactions.
// Expected latency, response and data are computed from the slave's programmed delays and payloads.
// Define AXI_MASTER_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES = 16.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          i_start_read, i_start_write;
  logic [DW-1:0] o_data;
  logic          o_read_done, o_write_done, o_busy, o_error;
  logic          AR_VALID, AR_READY;
  logic [AW-1:0] AR_ADDR;
  logic [2:0]    AR_PROT;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          R_VALID, R_READY;
  logic          AW_VALID, AW_READY;
  logic [AW-1:0] AW_ADDR;
  logic [2:0]    AW_PROT;
  logic [DW-1:0] W_DATA;
  logic [DW/8-1:0] W_STRB;
  logic          W_VALID, W_READY;
  logic [1:0]    B_RESP;
  logic          B_VALID, B_READY;

  axi4_lite_master #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .arst(arst),
    .i_addr(i_addr), .i_data(i_data),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .o_data(o_data), .o_read_done(o_read_done), .o_write_done(o_write_done),
    .o_busy(o_busy), .o_error(o_error),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to a quiet point: just after the falling edge, once the slave has updated.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // ---------------- slave model ----------------
  int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
  logic [31:0] rdata_cfg;
  logic [1:0]  rresp_cfg, bresp_cfg;
  bit          slave_clear, allow_drop;
  int          ar_cnt, aw_cnt, w_cnt;
  logic [63:0] ar_addr_seen, aw_addr_seen, ar_wait_addr;
  logic [31:0] w_data_seen;
  logic [3:0]  w_strb_seen;
  logic [2:0]  ar_prot_seen, aw_prot_seen;
  int          ar_age, r_age, aw_age, w_age, b_age;
  bit          r_pend, b_pend, aw_got, w_got;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
  bit          ar_wait, aw_wait, w_wait;

  initial begin
    AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 0;
    AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    ar_addr_seen = '0; aw_addr_seen = '0; ar_wait_addr = '0;
    w_data_seen = '0; w_strb_seen = '0; ar_prot_seen = '0; aw_prot_seen = '0;
    forever begin
      @(negedge clk);
      if (arst || slave_clear) begin
        AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
        ar_age = 0; r_age = 0; aw_age = 0; w_age = 0; b_age = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
      end else begin
        // A VALID that did not handshake at the last rising edge must still be up.
        if (!allow_drop) begin
          if (ar_wait) begin
            check("ar_valid_held", 64'(AR_VALID), 64'd1);
            check("ar_addr_stable", AR_ADDR, ar_wait_addr);
          end
          if (aw_wait) check("aw_valid_held", 64'(AW_VALID), 64'd1);
          if (w_wait)  check("w_valid_held", 64'(W_VALID), 64'd1);
        end
        // Account for handshakes that occurred at the rising edge just passed.
        if (ar_hs) begin ar_cnt++; ar_age = 0; r_pend = 1; r_age = 0; end
        if (r_hs)  r_pend = 0;
        if (aw_hs) begin aw_cnt++; aw_age = 0; aw_got = 1; end
        if (w_hs)  begin w_cnt++; w_age = 0; w_got = 1; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_age = 0; end
        if (b_hs)  b_pend = 0;

        AR_READY = AR_VALID && (ar_age >= ar_delay);
        if (AR_VALID && !AR_READY) ar_age++;
        R_VALID = r_pend && (r_age >= r_delay);
        R_DATA  = rdata_cfg;
        R_RESP  = rresp_cfg;
        if (r_pend && !R_VALID) r_age++;
        AW_READY = AW_VALID && (aw_age >= aw_delay);
        if (AW_VALID && !AW_READY) aw_age++;
        W_READY = W_VALID && (w_age >= w_delay);
        if (W_VALID && !W_READY) w_age++;
        B_VALID = b_pend && (b_age >= b_delay);
        B_RESP  = bresp_cfg;
        if (b_pend && !B_VALID) b_age++;

        // Nothing changes until the next rising edge, so these are the coming handshakes.
        ar_hs = AR_VALID && AR_READY;
        r_hs  = R_VALID && R_READY;
        aw_hs = AW_VALID && AW_READY;
        w_hs  = W_VALID && W_READY;
        b_hs  = B_VALID && B_READY;
        if (ar_hs) begin ar_addr_seen = AR_ADDR; ar_prot_seen = AR_PROT; end
        if (aw_hs) begin aw_addr_seen = AW_ADDR; aw_prot_seen = AW_PROT; end
        if (w_hs)  begin w_data_seen = W_DATA; w_strb_seen = W_STRB; end
        ar_wait = AR_VALID && !AR_READY; ar_wait_addr = AR_ADDR;
        aw_wait = AW_VALID && !AW_READY;
        w_wait  = W_VALID && !W_READY;
      end
    end
  end

  // ---------------- reference model + transaction driver ----------------
  logic [31:0] last_rdata;

  // mode: 0 normal, 1 read+write starts together, 2 stray write start while busy,
  //       3 return in the done cycle so the next start lands there.
  task automatic do_txn(input bit rd, input logic [63:0] addr, input logic [31:0] dat,
                        input logic [1:0] resp, input int d1, input int d2, input int d3,
                        input int mode);
    int lat, exp_lat, ar0, aw0, w0;
    bit seen;
    if (rd) begin ar_delay = d1; r_delay = d2; rdata_cfg = dat; rresp_cfg = resp; end
    else    begin aw_delay = d1; w_delay = d2; b_delay = d3; bresp_cfg = resp; end
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    i_addr        = addr;
    i_data        = rd ? $urandom : dat;
    i_start_read  = rd;
    i_start_write = !rd || (mode == 1);
    lat = 0; seen = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      step();
      if (i == 1) begin
        i_start_read = 0; i_start_write = 0;
        check("busy_after_start", 64'(o_busy), 64'd1);
      end
      if (mode == 2) i_start_write = (i == 2);
      if (o_read_done || o_write_done) begin seen = 1; lat = i; end
    end
    i_start_write = 0;
    exp_lat = rd ? 3 + d1 + d2 : 3 + ((d1 > d2) ? d1 : d2) + d3;
    check("latency", 64'(lat), 64'(exp_lat));
    check("read_done", 64'(o_read_done), 64'(rd));
    check("write_done", 64'(o_write_done), 64'(!rd));
    check("error", 64'(o_error), 64'(resp != RESP_OKAY));
    if (rd) last_rdata = dat;
    check("o_data", 64'(o_data), 64'(last_rdata));
    check("ar_count", 64'(ar_cnt - ar0), 64'(rd));
    check("aw_count", 64'(aw_cnt - aw0), 64'(!rd));
    check("w_count", 64'(w_cnt - w0), 64'(!rd));
    if (rd) begin
      check("ar_addr", ar_addr_seen, addr);
      check("ar_prot", 64'(ar_prot_seen), 64'd0);
    end else begin
      check("aw_addr", aw_addr_seen, addr);
      check("aw_prot", 64'(aw_prot_seen), 64'd0);
      check("w_data", 64'(w_data_seen), 64'(dat));
      check("w_strb", 64'(w_strb_seen), 64'hF);
    end
    if (mode != 3) begin
      step();
      check("done_one_pulse", 64'({o_read_done, o_write_done, o_error}), 64'd0);
      check("idle_not_busy", 64'(o_busy), 64'd0);
      if (mode == 2) begin
        step(); step(); step();
        check("stray_start_ignored", 64'(aw_cnt - aw0), 64'd0);
        check("stray_not_busy", 64'(o_busy), 64'd0);
      end
    end
  endtask

  int  t_lat;
  bit  t_seen;

  initial begin
    arst = 1; i_addr = '0; i_data = '0; i_start_read = 0; i_start_write = 0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    rdata_cfg = '0; rresp_cfg = RESP_OKAY; bresp_cfg = RESP_OKAY;
    slave_clear = 0; allow_drop = 0; last_rdata = '0;
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valids", 64'({AR_VALID, AW_VALID, W_VALID}), 64'd0);
    check("rst_readys", 64'({R_READY, B_READY}), 64'd0);
    check("rst_done_err", 64'({o_read_done, o_write_done, o_error}), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_addr", AR_ADDR, 64'd0);
    i_start_read = 1;
    step(); step();
    check("start_held_in_reset", 64'(o_busy), 64'd0);
    i_start_read = 0;
    arst = 0;
    step();

    do_txn(1, 64'h1000, 32'hDEADBEEF, RESP_OKAY, 2, 0, 0, 0);
    do_txn(0, 64'h2000, 32'hCAFEF00D, RESP_OKAY, 2, 0, 0, 0);
    do_txn(1, 64'h3000, 32'h12345678, RESP_OKAY, 0, 0, 0, 1);
    do_txn(0, 64'h3004, 32'h0BADF00D, RESP_OKAY, 0, 0, 0, 0);
    do_txn(1, 64'h3008, 32'hA5A5_5A5A, RESP_OKAY, 1, 1, 0, 2);
    do_txn(0, 64'h3010, 32'h1111_2222, RESP_SLVERR, 0, 0, 1, 0);
    do_txn(1, 64'h3014, 32'h3333_4444, RESP_SLVERR, 0, 2, 0, 0);
    do_txn(0, 64'h3018, 32'h5555_6666, RESP_OKAY, 1, 1, 0, 0);
    do_txn(0, 64'h301C, 32'h7777_8888, RESP_OKAY, 0, 3, 0, 3);
    do_txn(1, 64'h3020, 32'h9999_AAAA, RESP_OKAY, 0, 0, 0, 3);
    do_txn(0, 64'h3024, 32'hBBBB_CCCC, RESP_OKAY, 0, 0, 0, 0);

    // Reset while waiting for read data.
    ar_delay = 0; r_delay = 8; rdata_cfg = 32'hFEEDFACE; rresp_cfg = RESP_OKAY;
    i_addr = 64'h4000; i_start_read = 1;
    step();
    i_start_read = 0;
    for (int i = 0; i < 10 && !R_READY; i++) step();
    check("reached_rd_data", 64'(R_READY), 64'd1);
    step();
    arst = 1;
    #1;
    check("arst_ar_valid", 64'(AR_VALID), 64'd0);
    check("arst_r_ready", 64'(R_READY), 64'd0);
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_o_data", 64'(o_data), 64'd0);
    last_rdata = '0;
    step();
    arst = 0;
    step();
    do_txn(1, 64'h5000, 32'h0F0F_F0F0, RESP_OKAY, 1, 1, 0, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
    // Slave never accepts the address: the watchdog must end the read.
    allow_drop = 1; ar_delay = 100000;
    i_addr = 64'h6000; i_start_read = 1;
    t_lat = 0; t_seen = 0;
    for (int i = 1; i <= 100 && !t_seen; i++) begin
      step();
      if (i == 1) i_start_read = 0;
      if (o_read_done || o_write_done) begin t_seen = 1; t_lat = i; end
    end
    check("tmo_latency", 64'(t_lat), 64'(TMO + 1));
    check("tmo_read_done", 64'(o_read_done), 64'd1);
    check("tmo_error", 64'(o_error), 64'd1);
    check("tmo_ar_valid", 64'(AR_VALID), 64'd0);
    check("tmo_busy", 64'(o_busy), 64'd0);
    slave_clear = 1;
    step();
    slave_clear = 0; allow_drop = 0;
    step();
`endif

    for (int k = 0; k < 30; k++) begin
      do_txn(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 3 : 0);
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
